ysyx_25040129_axil_xbar_1ton: RTL and testbench

//  AXI4-Lite 1-to-N crossbar between the core LSU/IFU arbiter and N downstream slaves (SoC bus, CLINT/RTC, ...).

---
 rtl/ysyx_25040129_xbar_pkg.sv | 31 +++
 rtl/ysyx_25040129_xbar_dec.sv | 30 +++
 rtl/ysyx_25040129_axil_xbar_1ton.sv | 218 +++++++++++++++++++++
 tb/tb_ysyx_25040129_axil_xbar_1ton.sv | 288 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ysyx_25040129_xbar_pkg.sv
// Shared types for the AXI4-Lite 1-to-N crossbar: response codes, FSM states,
// and the saturating error-counter helper.
package ysyx_25040129_xbar_pkg;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    localparam logic [1:0] RESP_DECERR = 2'b11;

    typedef enum logic [2:0] {
        R_IDLE,
        R_ADDR,
        R_DATA,
        R_EARD,
        R_ERSP
    } rd_state_e;

    typedef enum logic [2:0] {
        W_IDLE,
        W_FWD,
        W_RESP,
        W_EADR,
        W_ERSP
    } wr_state_e;

    function automatic logic [7:0] sat_add8(input logic [7:0] a, input logic [1:0] b);
        logic [8:0] s;
        s = {1'b0, a} + {7'd0, b};
        return s[8] ? 8'hFF : s[7:0];
    endfunction

endpackage

// File: rtl/ysyx_25040129_xbar_dec.sv
// Address decoder: matches addr against per-slave base/mask windows,
// lowest index wins; reports hit, one-hot select and binary index.
module ysyx_25040129_xbar_dec #(
    parameter int                     N_SLV    = 3,
    parameter int                     ADDR_W   = 32,
    parameter int                     IDX_W    = 2,
    parameter logic [N_SLV*ADDR_W-1:0] SLV_BASE = '0,
    parameter logic [N_SLV*ADDR_W-1:0] SLV_MASK = '0
) (
    input  logic [ADDR_W-1:0] addr,
    output logic              hit,
    output logic [N_SLV-1:0]  sel,
    output logic [IDX_W-1:0]  idx
);

    always_comb begin
        sel = '0;
        idx = '0;
        // Walk downwards so the lowest matching index is the one left standing.
        for (int i = N_SLV - 1; i >= 0; i--) begin
            if ((addr & SLV_MASK[i*ADDR_W +: ADDR_W]) == SLV_BASE[i*ADDR_W +: ADDR_W]) begin
                sel    = '0;
                sel[i] = 1'b1;
                idx    = IDX_W'(i);
            end
        end
        hit = |sel;
    end

endmodule

// File: rtl/ysyx_25040129_axil_xbar_1ton.sv
// AXI4-Lite 1-to-N crossbar: independent read and write FSMs, local DECERR for
// unmapped addresses and SLVERR for writes to read-only slaves.
module ysyx_25040129_axil_xbar_1ton
    import ysyx_25040129_xbar_pkg::*;
#(
    parameter int                      N_SLV     = 3,
    parameter int                      ADDR_W    = 32,
    parameter int                      DATA_W    = 32,
    parameter logic [N_SLV*ADDR_W-1:0] SLV_BASE  = {32'h1000_0000, 32'h0200_0000, 32'h0000_0000},
    parameter logic [N_SLV*ADDR_W-1:0] SLV_MASK  = {32'hFFFF_F000, 32'hFF00_0000, 32'h0000_0000},
    parameter logic [N_SLV-1:0]        SLV_WR_EN = 3'b101,
    localparam int                     STRB_W    = DATA_W / 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [ADDR_W-1:0]        araddr,
    input  logic                     arvalid,
    input  logic [2:0]               arsize,
    output logic                     arready,
    output logic [DATA_W-1:0]        rdata,
    output logic [1:0]               rresp,
    output logic                     rvalid,
    input  logic                     rready,
    input  logic [ADDR_W-1:0]        awaddr,
    input  logic                     awvalid,
    output logic                     awready,
    input  logic [DATA_W-1:0]        wdata,
    input  logic [STRB_W-1:0]        wstrb,
    input  logic                     wvalid,
    output logic                     wready,
    output logic [1:0]               bresp,
    output logic                     bvalid,
    input  logic                     bready,
    output logic [N_SLV*ADDR_W-1:0]  m_araddr,
    output logic [N_SLV-1:0]         m_arvalid,
    output logic [N_SLV*3-1:0]       m_arsize,
    input  logic [N_SLV-1:0]         m_arready,
    input  logic [N_SLV*DATA_W-1:0]  m_rdata,
    input  logic [N_SLV*2-1:0]       m_rresp,
    input  logic [N_SLV-1:0]         m_rvalid,
    output logic [N_SLV-1:0]         m_rready,
    output logic [N_SLV*ADDR_W-1:0]  m_awaddr,
    output logic [N_SLV-1:0]         m_awvalid,
    input  logic [N_SLV-1:0]         m_awready,
    output logic [N_SLV*DATA_W-1:0]  m_wdata,
    output logic [N_SLV*STRB_W-1:0]  m_wstrb,
    output logic [N_SLV-1:0]         m_wvalid,
    input  logic [N_SLV-1:0]         m_wready,
    input  logic [N_SLV*2-1:0]       m_bresp,
    input  logic [N_SLV-1:0]         m_bvalid,
    output logic [N_SLV-1:0]         m_bready,
    output logic [7:0]               err_cnt
);

    localparam int IDX_W = (N_SLV > 1) ? $clog2(N_SLV) : 1;

    logic             ar_hit, aw_hit;
    logic [N_SLV-1:0] ar_sel, aw_sel;
    logic [IDX_W-1:0] ar_idx, aw_idx;

    ysyx_25040129_xbar_dec #(.N_SLV(N_SLV), .ADDR_W(ADDR_W), .IDX_W(IDX_W),
        .SLV_BASE(SLV_BASE), .SLV_MASK(SLV_MASK))
    u_ar_dec (.addr(araddr), .hit(ar_hit), .sel(ar_sel), .idx(ar_idx));

    ysyx_25040129_xbar_dec #(.N_SLV(N_SLV), .ADDR_W(ADDR_W), .IDX_W(IDX_W),
        .SLV_BASE(SLV_BASE), .SLV_MASK(SLV_MASK))
    u_aw_dec (.addr(awaddr), .hit(aw_hit), .sel(aw_sel), .idx(aw_idx));

    rd_state_e        r_state;
    wr_state_e        w_state;
    logic [N_SLV-1:0] r_oh, w_oh;
    logic [IDX_W-1:0] r_idx, w_idx;
    logic [1:0]       w_err_resp;
    logic             aw_done, w_done;

    // Read channel routing; the selection is registered, so slave ready never feeds slave valid.
    always_comb begin
        m_araddr  = '0;
        m_arsize  = '0;
        m_arvalid = '0;
        m_rready  = '0;
        arready   = 1'b0;
        rvalid    = 1'b0;
        rdata     = '0;
        rresp     = RESP_OKAY;
        case (r_state)
            R_ADDR: begin
                m_arvalid = r_oh & {N_SLV{arvalid}};
                for (int i = 0; i < N_SLV; i++) begin
                    if (r_oh[i]) begin
                        m_araddr[i*ADDR_W +: ADDR_W] = araddr;
                        m_arsize[i*3 +: 3]           = arsize;
                    end
                end
                arready = |(r_oh & m_arready);
            end
            R_DATA: begin
                m_rready = r_oh & {N_SLV{rready}};
                rvalid   = m_rvalid[r_idx];
                rdata    = m_rdata[r_idx*DATA_W +: DATA_W];
                rresp    = m_rresp[r_idx*2 +: 2];
            end
            R_EARD: arready = 1'b1;
            R_ERSP: begin
                rvalid = 1'b1;
                rresp  = RESP_DECERR;
            end
            default: ;
        endcase
    end

    // Write channel routing; AW and W are masked off individually once accepted.
    always_comb begin
        m_awaddr  = '0;
        m_awvalid = '0;
        m_wdata   = '0;
        m_wstrb   = '0;
        m_wvalid  = '0;
        m_bready  = '0;
        awready   = 1'b0;
        wready    = 1'b0;
        bvalid    = 1'b0;
        bresp     = RESP_OKAY;
        case (w_state)
            W_FWD: begin
                m_awvalid = w_oh & {N_SLV{awvalid & ~aw_done}};
                m_wvalid  = w_oh & {N_SLV{wvalid & ~w_done}};
                for (int i = 0; i < N_SLV; i++) begin
                    if (w_oh[i]) begin
                        m_awaddr[i*ADDR_W +: ADDR_W] = awaddr;
                        m_wdata[i*DATA_W +: DATA_W]  = wdata;
                        m_wstrb[i*STRB_W +: STRB_W]  = wstrb;
                    end
                end
                awready = ~aw_done & |(w_oh & m_awready);
                wready  = ~w_done & |(w_oh & m_wready);
            end
            W_RESP: begin
                m_bready = w_oh & {N_SLV{bready}};
                bvalid   = m_bvalid[w_idx];
                bresp    = m_bresp[w_idx*2 +: 2];
            end
            W_EADR: begin
                awready = 1'b1;
                wready  = 1'b1;
            end
            W_ERSP: begin
                bvalid = 1'b1;
                bresp  = w_err_resp;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= R_IDLE;
            r_oh    <= '0;
            r_idx   <= '0;
        end else begin
            case (r_state)
                R_IDLE: if (arvalid) begin
                    r_oh    <= ar_sel;
                    r_idx   <= ar_idx;
                    r_state <= ar_hit ? R_ADDR : R_EARD;
                end
                R_ADDR:  if (arvalid && arready) r_state <= R_DATA;
                R_DATA:  if (rvalid && rready) r_state <= R_IDLE;
                R_EARD:  r_state <= R_ERSP;
                R_ERSP:  if (rready) r_state <= R_IDLE;
                default: r_state <= R_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            w_state    <= W_IDLE;
            w_oh       <= '0;
            w_idx      <= '0;
            w_err_resp <= RESP_OKAY;
            aw_done    <= 1'b0;
            w_done     <= 1'b0;
        end else begin
            case (w_state)
                W_IDLE: if (awvalid && wvalid) begin
                    w_oh       <= aw_sel;
                    w_idx      <= aw_idx;
                    aw_done    <= 1'b0;
                    w_done     <= 1'b0;
                    w_err_resp <= aw_hit ? RESP_SLVERR : RESP_DECERR;
                    w_state    <= (aw_hit && |(aw_sel & SLV_WR_EN)) ? W_FWD : W_EADR;
                end
                W_FWD: begin
                    aw_done <= aw_done | (awvalid & awready);
                    w_done  <= w_done | (wvalid & wready);
                    if ((aw_done | (awvalid & awready)) && (w_done | (wvalid & wready)))
                        w_state <= W_RESP;
                end
                W_RESP:  if (bvalid && bready) w_state <= W_IDLE;
                W_EADR:  w_state <= W_ERSP;
                W_ERSP:  if (bready) w_state <= W_IDLE;
                default: w_state <= W_IDLE;
            endcase
        end
    end

    // Only locally generated error responses are counted, not slave errors passed through.
    always_ff @(posedge clk) begin
        if (rst) begin
            err_cnt <= '0;
        end else begin
            err_cnt <= sat_add8(err_cnt, {1'b0, (r_state == R_ERSP) && rready}
                                       + {1'b0, (w_state == W_ERSP) && bready});
        end
    end

endmodule

// File: tb/tb_ysyx_25040129_axil_xbar_1ton.sv
// Directed bench for the AXI4-Lite 1-to-N crossbar with hand-computed expectations.
module tb_ysyx_25040129_axil_xbar_1ton;

    localparam int N = 3;
    localparam int AW = 32;
    localparam int DW = 32;
    localparam int SW = DW / 8;

    // Slave 0 sits in the upper half so that the three windows are disjoint.
    localparam logic [N*AW-1:0] BASE = {32'h1000_0000, 32'h0200_0000, 32'h8000_0000};
    localparam logic [N*AW-1:0] MASK = {32'hFFFF_F000, 32'hFF00_0000, 32'h8000_0000};
    localparam logic [N-1:0]    WREN = 3'b101;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic [AW-1:0] araddr = '0;
    logic arvalid = 1'b0;
    logic [2:0] arsize = 3'd2;
    logic arready;
    logic [DW-1:0] rdata;
    logic [1:0] rresp;
    logic rvalid;
    logic rready = 1'b0;
    logic [AW-1:0] awaddr = '0;
    logic awvalid = 1'b0;
    logic awready;
    logic [DW-1:0] wdata = '0;
    logic [SW-1:0] wstrb = '0;
    logic wvalid = 1'b0;
    logic wready;
    logic [1:0] bresp;
    logic bvalid;
    logic bready = 1'b0;
    logic [N*AW-1:0] m_araddr;
    logic [N-1:0] m_arvalid;
    logic [N*3-1:0] m_arsize;
    logic [N-1:0] m_arready = '0;
    logic [N*DW-1:0] m_rdata = '0;
    logic [N*2-1:0] m_rresp = '0;
    logic [N-1:0] m_rvalid = '0;
    logic [N-1:0] m_rready;
    logic [N*AW-1:0] m_awaddr;
    logic [N-1:0] m_awvalid;
    logic [N-1:0] m_awready = '0;
    logic [N*DW-1:0] m_wdata;
    logic [N*SW-1:0] m_wstrb;
    logic [N-1:0] m_wvalid;
    logic [N-1:0] m_wready = '0;
    logic [N*2-1:0] m_bresp = '0;
    logic [N-1:0] m_bvalid = '0;
    logic [N-1:0] m_bready;
    logic [7:0] err_cnt;

    int checks = 0;
    int errors = 0;
    logic saw_soc_ar = 1'b0;
    int uart_w_hs = 0;

    ysyx_25040129_axil_xbar_1ton #(
        .N_SLV(N), .ADDR_W(AW), .DATA_W(DW),
        .SLV_BASE(BASE), .SLV_MASK(MASK), .SLV_WR_EN(WREN)
    ) dut (
        .clk(clk), .rst(rst),
        .araddr(araddr), .arvalid(arvalid), .arsize(arsize), .arready(arready),
        .rdata(rdata), .rresp(rresp), .rvalid(rvalid), .rready(rready),
        .awaddr(awaddr), .awvalid(awvalid), .awready(awready),
        .wdata(wdata), .wstrb(wstrb), .wvalid(wvalid), .wready(wready),
        .bresp(bresp), .bvalid(bvalid), .bready(bready),
        .m_araddr(m_araddr), .m_arvalid(m_arvalid), .m_arsize(m_arsize), .m_arready(m_arready),
        .m_rdata(m_rdata), .m_rresp(m_rresp), .m_rvalid(m_rvalid), .m_rready(m_rready),
        .m_awaddr(m_awaddr), .m_awvalid(m_awvalid), .m_awready(m_awready),
        .m_wdata(m_wdata), .m_wstrb(m_wstrb), .m_wvalid(m_wvalid), .m_wready(m_wready),
        .m_bresp(m_bresp), .m_bvalid(m_bvalid), .m_bready(m_bready),
        .err_cnt(err_cnt)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (!rst && m_arvalid[0]) saw_soc_ar = 1'b1;
        if (m_wvalid[2] && m_wready[2]) uart_w_hs++;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    initial begin
        int hs0;
        tick();
        tick();
        rst = 1'b0;
        settle();
        chk("rst_arready", 32'(arready), 32'd0);
        chk("rst_rvalid", 32'(rvalid), 32'd0);
        chk("rst_bvalid", 32'(bvalid), 32'd0);
        chk("rst_rdata", rdata, 32'd0);
        chk("rst_err_cnt", 32'(err_cnt), 32'd0);
        chk("rst_m_valids", {26'd0, m_arvalid, m_awvalid}, 32'd0);

        // Read from the read-only RTC window.
        tick();
        araddr = 32'h0200_0048; arvalid = 1'b1;
        settle();
        chk("rd_idle_arready", 32'(arready), 32'd0);
        tick();
        chk("rd_m_arvalid", 32'(m_arvalid), 32'b010);
        chk("rd_m_araddr", m_araddr[32 +: 32], 32'h0200_0048);
        chk("rd_m_araddr_unsel", m_araddr[64 +: 32], 32'd0);
        m_arready = 3'b010;
        settle();
        chk("rd_arready", 32'(arready), 32'd1);
        tick();
        arvalid = 1'b0; m_arready = '0;
        m_rdata[32 +: 32] = 32'h0000_1234; m_rvalid = 3'b010; rready = 1'b1;
        settle();
        chk("rd_rvalid", 32'(rvalid), 32'd1);
        chk("rd_rdata", rdata, 32'h0000_1234);
        chk("rd_rresp", 32'(rresp), 32'd0);
        chk("rd_m_rready", 32'(m_rready), 32'b010);
        tick();
        m_rvalid = '0; rready = 1'b0; m_rdata = '0;
        settle();
        chk("rd_done_rvalid", 32'(rvalid), 32'd0);
        chk("rd_soc_never_ar", 32'(saw_soc_ar), 32'd0);

        // Write to the read-only RTC window -> local SLVERR.
        awaddr = 32'h0200_0000; awvalid = 1'b1; wdata = 32'hDEAD_BEEF; wstrb = 4'hF; wvalid = 1'b1;
        tick();
        chk("ro_awready", 32'(awready), 32'd1);
        chk("ro_wready", 32'(wready), 32'd1);
        chk("ro_no_slave_valid", {29'd0, m_awvalid | m_wvalid}, 32'd0);
        tick();
        awvalid = 1'b0; wvalid = 1'b0;
        settle();
        chk("ro_bvalid", 32'(bvalid), 32'd1);
        chk("ro_bresp", 32'(bresp), 32'b10);
        chk("ro_err_before", 32'(err_cnt), 32'd0);
        bready = 1'b1;
        tick();
        bready = 1'b0;
        settle();
        chk("ro_err_after", 32'(err_cnt), 32'd1);
        chk("ro_bvalid_done", 32'(bvalid), 32'd0);

        // Unmapped read -> DECERR, response held while rready is low.
        araddr = 32'h3000_0000; arvalid = 1'b1;
        tick();
        chk("ur_arready", 32'(arready), 32'd1);
        chk("ur_m_arvalid", 32'(m_arvalid), 32'd0);
        tick();
        arvalid = 1'b0;
        for (int i = 0; i < 5; i++) begin
            settle();
            chk("ur_rvalid_hold", 32'(rvalid), 32'd1);
            tick();
        end
        chk("ur_rresp", 32'(rresp), 32'b11);
        chk("ur_rdata", rdata, 32'd0);
        chk("ur_err_hold", 32'(err_cnt), 32'd1);
        rready = 1'b1;
        tick();
        rready = 1'b0;
        settle();
        chk("ur_err_after", 32'(err_cnt), 32'd2);

        // Concurrent read (RTC) and write (UART) with junk on the other slaves.
        araddr = 32'h0200_0000; arvalid = 1'b1;
        awaddr = 32'h1000_0004; awvalid = 1'b1; wdata = 32'hA5A5_0F0F; wstrb = 4'h3; wvalid = 1'b1;
        tick();
        chk("cc_m_arvalid", 32'(m_arvalid), 32'b010);
        chk("cc_m_awvalid", 32'(m_awvalid), 32'b100);
        chk("cc_m_wvalid", 32'(m_wvalid), 32'b100);
        chk("cc_m_awaddr", m_awaddr[64 +: 32], 32'h1000_0004);
        chk("cc_m_wdata", m_wdata[64 +: 32], 32'hA5A5_0F0F);
        chk("cc_m_wstrb", {20'd0, m_wstrb}, 32'h300);
        m_arready = 3'b010; m_awready = 3'b100; m_wready = 3'b100;
        settle();
        chk("cc_ready_all", {29'd0, arready, awready, wready}, 32'b111);
        tick();
        arvalid = 1'b0; awvalid = 1'b0; wvalid = 1'b0;
        m_arready = '0; m_awready = '0; m_wready = '0;
        m_rdata = {32'h1111_1111, 32'h0000_CAFE, 32'h2222_2222};
        m_rresp = 6'b11_00_10; m_rvalid = 3'b111;
        m_bresp = 6'b00_11_10; m_bvalid = 3'b111;
        rready = 1'b1; bready = 1'b1;
        settle();
        chk("cc_rdata", rdata, 32'h0000_CAFE);
        chk("cc_rresp", 32'(rresp), 32'd0);
        chk("cc_bvalid", 32'(bvalid), 32'd1);
        chk("cc_bresp", 32'(bresp), 32'd0);
        chk("cc_m_rready", 32'(m_rready), 32'b010);
        chk("cc_m_bready", 32'(m_bready), 32'b100);
        tick();
        rready = 1'b0; bready = 1'b0; m_rvalid = '0; m_bvalid = '0; m_rresp = '0; m_bresp = '0; m_rdata = '0;
        settle();
        chk("cc_idle", {30'd0, rvalid, bvalid}, 32'd0);
        chk("cc_err", 32'(err_cnt), 32'd2);

        // W accepted three cycles before AW; W must not be re-offered.
        hs0 = uart_w_hs;
        awaddr = 32'h1000_0010; awvalid = 1'b1; wdata = 32'h0BAD_F00D; wstrb = 4'hF; wvalid = 1'b1;
        tick();
        m_wready = 3'b100;
        settle();
        chk("wf_wready_first", 32'(wready), 32'd1);
        chk("wf_awready_wait", 32'(awready), 32'd0);
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("wf_wready_forced", 32'(wready), 32'd0);
            chk("wf_m_wvalid_off", 32'(m_wvalid), 32'd0);
            chk("wf_m_awvalid_on", 32'(m_awvalid), 32'b100);
        end
        m_awready = 3'b100;
        settle();
        chk("wf_awready", 32'(awready), 32'd1);
        tick();
        awvalid = 1'b0; wvalid = 1'b0; m_awready = '0; m_wready = '0;
        m_bresp = 6'b10_00_00; m_bvalid = 3'b100; bready = 1'b1;
        settle();
        chk("wf_bresp_passthru", 32'(bresp), 32'b10);
        tick();
        m_bvalid = '0; m_bresp = '0; bready = 1'b0;
        settle();
        chk("wf_single_w_hs", 32'(uart_w_hs - hs0), 32'd1);
        chk("wf_slverr_not_counted", 32'(err_cnt), 32'd2);

        // Reset while in R_DATA abandons the read.
        araddr = 32'h1000_0000; arvalid = 1'b1;
        tick();
        m_arready = 3'b100;
        tick();
        arvalid = 1'b0; m_arready = '0; m_rvalid = 3'b100;
        settle();
        chk("rs_rvalid_before", 32'(rvalid), 32'd1);
        rst = 1'b1;
        tick();
        chk("rs_rvalid", 32'(rvalid), 32'd0);
        chk("rs_m_rready", 32'(m_rready), 32'd0);
        chk("rs_err_cnt", 32'(err_cnt), 32'd0);
        rst = 1'b0; m_rvalid = '0;
        tick();

        // Read and write local errors completing together -> +2.
        araddr = 32'h3000_0000; arvalid = 1'b1;
        awaddr = 32'h4000_0000; awvalid = 1'b1; wvalid = 1'b1;
        tick();
        tick();
        arvalid = 1'b0; awvalid = 1'b0; wvalid = 1'b0; rready = 1'b1; bready = 1'b1;
        settle();
        chk("dual_bresp", 32'(bresp), 32'b11);
        tick();
        rready = 1'b0; bready = 1'b0;
        settle();
        chk("dual_err_cnt", 32'(err_cnt), 32'd2);

        // Back-to-back unmapped reads drive err_cnt into saturation.
        araddr = 32'h3000_0000; arvalid = 1'b1; rready = 1'b1;
        for (int i = 0; i < 800; i++) tick();
        arvalid = 1'b0;
        for (int i = 0; i < 4; i++) tick();
        rready = 1'b0;
        chk("sat_err_cnt", 32'(err_cnt), 32'hFF);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "timeout");
    end

endmodule
